// File: rtl/icache_line_buffer_if.sv
// rtl/icache_line_buffer_if.sv - fetch-side and refill-side signal bundle for icache_line_buffer
interface icache_line_buffer_if #(
    parameter int ADDR_W = 32
);
    logic              req_i;
    logic [ADDR_W-1:0] addr_i;
    logic              flush_i;
    logic [31:0]       instr_o;
    logic              ack_o;
    logic              mem_req_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic              mem_gnt_i;
    logic [31:0]       mem_rdata_i;
    logic              mem_rvalid_i;

    modport master (
        output req_i, addr_i, flush_i, mem_gnt_i, mem_rdata_i, mem_rvalid_i,
        input  instr_o, ack_o, mem_req_o, mem_addr_o
    );

    modport slave (
        input  req_i, addr_i, flush_i, mem_gnt_i, mem_rdata_i, mem_rvalid_i,
        output instr_o, ack_o, mem_req_o, mem_addr_o
    );
endinterface

// File: rtl/icache_line_buffer.sv
// rtl/icache_line_buffer.sv - single-line instruction buffer with burst refill; ICACHE_LB_EARLY_ACK_EN enables critical-word ack
module icache_line_buffer #(
    parameter int LINE_WORDS = 4,
    parameter int ADDR_W     = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    icache_line_buffer_if.slave   bus
);
    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int TAG_W = ADDR_W - OFF_W - 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REFILL_REQ,
        S_REFILL_DATA,
        S_RESP
    } state_e;

    state_e             state_q, state_d;
    logic               valid_q, valid_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [TAG_W-1:0]   req_tag_q, req_tag_d;
    logic [OFF_W-1:0]   cnt_q, cnt_d;
    logic [OFF_W-1:0]   idx_q, idx_d;
    logic               flushed_q, flushed_d;
    logic [31:0]        instr_q, instr_d;
    logic               ack_q, ack_d;
    logic [31:0]        data_q [LINE_WORDS];

    logic [TAG_W-1:0]   addr_tag;
    logic [OFF_W-1:0]   addr_idx;
    logic               hit;
    logic               last_beat;
    logic               beat_we;
    logic               kill;
    logic               unused_addr;

    assign addr_tag    = bus.addr_i[ADDR_W-1:OFF_W+2];
    assign addr_idx    = bus.addr_i[OFF_W+1:2];
    assign unused_addr = ^bus.addr_i[1:0];
    assign hit         = valid_q && (tag_q == addr_tag);
    assign last_beat   = (cnt_q == OFF_W'(LINE_WORDS - 1));
    assign beat_we     = (state_q == S_REFILL_DATA) && bus.mem_rvalid_i;
    // A flush seen at any point of the refill poisons the line being filled.
    assign kill        = flushed_q || bus.flush_i;

    assign bus.instr_o    = instr_q;
    assign bus.ack_o      = ack_q;
    assign bus.mem_req_o  = (state_q == S_REFILL_REQ);
    assign bus.mem_addr_o = (state_q == S_REFILL_REQ) ? {req_tag_q, {(OFF_W+2){1'b0}}}
                                                      : '0;

    always_comb begin
        state_d   = state_q;
        valid_d   = valid_q;
        tag_d     = tag_q;
        req_tag_d = req_tag_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        flushed_d = flushed_q;
        instr_d   = instr_q;
        ack_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.req_i && !bus.flush_i) begin
                    if (hit) begin
                        instr_d = data_q[addr_idx];
                        ack_d   = 1'b1;
                    end else begin
                        req_tag_d = addr_tag;
                        idx_d     = addr_idx;
                        valid_d   = 1'b0;
                        flushed_d = 1'b0;
                        state_d   = S_REFILL_REQ;
                    end
                end
            end
            S_REFILL_REQ: begin
                if (bus.mem_gnt_i) begin
                    cnt_d   = '0;
                    state_d = S_REFILL_DATA;
                end
            end
            S_REFILL_DATA: begin
                if (bus.mem_rvalid_i) begin
                    cnt_d = cnt_q + 1'b1;
`ifdef ICACHE_LB_EARLY_ACK_EN
                    if ((cnt_q == idx_q) && !kill) begin
                        instr_d = bus.mem_rdata_i;
                        ack_d   = 1'b1;
                    end
                    if (last_beat) begin
                        if (!kill) begin
                            valid_d = 1'b1;
                            tag_d   = req_tag_q;
                        end
                        state_d = S_IDLE;
                    end
`else
                    if (last_beat) begin
                        if (kill) begin
                            state_d = S_IDLE;
                        end else begin
                            valid_d = 1'b1;
                            tag_d   = req_tag_q;
                            // The requested word may be the beat landing this cycle.
                            instr_d = (idx_q == cnt_q) ? bus.mem_rdata_i : data_q[idx_q];
                            ack_d   = 1'b1;
                            state_d = S_RESP;
                        end
                    end
`endif
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (bus.flush_i) begin
            valid_d   = 1'b0;
            flushed_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            valid_q   <= 1'b0;
            tag_q     <= '0;
            req_tag_q <= '0;
            cnt_q     <= '0;
            idx_q     <= '0;
            flushed_q <= 1'b0;
            instr_q   <= '0;
            ack_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            valid_q   <= valid_d;
            tag_q     <= tag_d;
            req_tag_q <= req_tag_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            flushed_q <= flushed_d;
            instr_q   <= instr_d;
            ack_q     <= ack_d;
        end
    end

    always_ff @(posedge clk) begin
        if (beat_we) begin
            data_q[cnt_q] <= bus.mem_rdata_i;
        end
    end
endmodule

// File: tb/tb_icache_line_buffer.sv
// tb/tb_icache_line_buffer.sv - directed scoreboard bench for icache_line_buffer
module tb_icache_line_buffer;
`ifdef ICACHE_LB_EARLY_ACK_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    icache_line_buffer_if #(.ADDR_W(32)) bus ();

    icache_line_buffer #(.LINE_WORDS(4), .ADDR_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] exp_q[$];
    logic [31:0] line_data [4];
    int          gnt_delay = 2;
    int          gap_after = -1;
    int          m_beat = -1;
    int          m_wait = 0;
    bit          m_gap = 1'b0;
    int          refills = 0;
    int          beats = 0;
    int          n_acks = 0;
    int          beat_cyc [4];
    logic [31:0] last_addr = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Burst memory: grants after gnt_delay request cycles, then streams line_data.
    initial begin
        bus.mem_gnt_i    = 1'b0;
        bus.mem_rvalid_i = 1'b0;
        bus.mem_rdata_i  = '0;
        forever begin
            @(posedge clk); #1;
            bus.mem_gnt_i    = 1'b0;
            bus.mem_rvalid_i = 1'b0;
            if (m_beat >= 0) begin
                if (m_gap) begin
                    m_gap = 1'b0;
                end else begin
                    bus.mem_rvalid_i = 1'b1;
                    bus.mem_rdata_i  = line_data[m_beat];
                    beat_cyc[m_beat] = cyc;
                    beats++;
                    if (m_beat == gap_after) m_gap = 1'b1;
                    m_beat = (m_beat == 3) ? -1 : m_beat + 1;
                end
            end else if (bus.mem_req_o) begin
                if (m_wait == gnt_delay) begin
                    bus.mem_gnt_i = 1'b1;
                    last_addr = bus.mem_addr_o;
                    refills++;
                    m_wait = 0;
                    m_beat = 0;
                end else begin
                    m_wait++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && bus.ack_o) begin
            n_acks++;
            total++;
            assert (exp_q.size() != 0) else begin
                bad++;
                $error("FAIL unexpected_ack observed=%h expected=none", bus.instr_o);
            end
            if (exp_q.size() != 0) chk("ack_instr", bus.instr_o, exp_q.pop_front());
        end
    end

    task automatic fetch(input logic [31:0] a, input logic [31:0] exp,
                         output int start, output int ack_at);
        exp_q.push_back(exp);
        bus.req_i  = 1'b1;
        bus.addr_i = a;
        start      = cyc;
        ack_at     = -1;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if (bus.ack_o) begin
                ack_at = cyc;
                break;
            end
        end
        bus.req_i = 1'b0;
        chk("ack_timeout", 32'(ack_at >= 0), 32'd1);
    endtask

    task automatic settle();
        for (int i = 0; i < 40 && m_beat >= 0; i++) begin
            @(posedge clk); #1;
        end
        repeat (2) begin @(posedge clk); #1; end
    endtask

    initial begin
        int s, a, a2, r0, b0, k0;
        bus.req_i   = 1'b0;
        bus.addr_i  = '0;
        bus.flush_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack", 32'(bus.ack_o), 32'd0);
        chk("rst_instr", bus.instr_o, 32'd0);
        chk("rst_mem_req", 32'(bus.mem_req_o), 32'd0);
        chk("rst_mem_addr", bus.mem_addr_o, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Cold miss on 0x1000
        line_data = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
        fetch(32'h1000, 32'hA0, s, a);
        chk("miss1_addr", last_addr, 32'h1000);
        chk("miss1_lat", 32'(a), 32'(EARLY ? beat_cyc[0] + 1 : beat_cyc[3] + 1));
        settle();

        // Hit
        r0 = refills;
        fetch(32'h100C, 32'hA3, s, a);
        chk("hit_lat", 32'(a), 32'(s + 1));
        chk("hit_no_refill", 32'(refills), 32'(r0));

        // Back-to-back hits
        fetch(32'h1004, 32'hA1, s, a);
        fetch(32'h1008, 32'hA2, s, a2);
        chk("b2b_consecutive", 32'(a2), 32'(a + 1));
        chk("b2b_no_refill", 32'(refills), 32'(r0));

        // Miss with a gap after beat 1
        line_data = '{32'hB0, 32'hB1, 32'hB2, 32'hB3};
        gap_after = 1;
        fetch(32'h2006, 32'hB1, s, a);
        gap_after = -1;
        chk("miss2_addr", last_addr, 32'h2000);
        chk("miss2_lat", 32'(a), 32'(EARLY ? beat_cyc[1] + 1 : beat_cyc[3] + 1));
        settle();

        // Flush mid-refill: drained, no ack, later re-request refills again
        line_data = '{32'hD0, 32'hD1, 32'hD2, 32'hD3};
        k0 = n_acks;
        b0 = beats;
        r0 = refills;
        bus.req_i  = 1'b1;
        bus.addr_i = 32'h3000;
        for (int i = 0; i < 40 && m_beat < 2; i++) begin
            @(posedge clk); #1;
        end
        bus.flush_i = 1'b1;
        bus.req_i   = 1'b0;
        @(posedge clk); #1;
        bus.flush_i = 1'b0;
        settle();
        repeat (3) begin @(posedge clk); #1; end
        chk("flush_no_ack", 32'(n_acks), 32'(k0));
        chk("flush_drained", 32'(beats - b0), 32'd4);
        fetch(32'h3000, 32'hD0, s, a);
        chk("flush_rerefill", 32'(refills), 32'(r0 + 2));
        settle();

        // Critical-word timing and follow-up request during the refill
        line_data = '{32'hC0, 32'hC1, 32'hC2, 32'hC3};
        fetch(32'h4004, 32'hC1, s, a);
        chk("miss3_lat", 32'(a), 32'(EARLY ? beat_cyc[1] + 1 : beat_cyc[3] + 1));
        r0 = refills;
        fetch(32'h4008, 32'hC2, s, a2);
        chk("follow_lat", 32'(a2), 32'(EARLY ? beat_cyc[3] + 2 : a + 2));
        chk("follow_hit", 32'(refills), 32'(r0));
        settle();

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/icache_line_buffer.md
# icache_line_buffer

Instruction-side responder serving the prefetch stage's icache request interface (`type_if2icache_s` addr/req in, `type_icache2if_s` instr/ack out). It holds one cache line of instructions tagged by physical address. Hits answer with fixed one-cycle latency. Misses run a line refill over a simple burst memory port, then return the requested word. It sits between the prefetch FIFO and the instruction memory/bus, behind the MMU translation.

## Interface
- `LINE_WORDS`, default 4: 32-bit words per line; power of two, ≥2.
- `ADDR_W`, default 32: physical address width.
- `clk` in 1: clock.
- `rst_n` in 1: reset; synchronous, active-low.
- `req_i` in 1: fetch request (from `if2icache.req`).
- `addr_i` in ADDR_W: fetch physical address (from `if2icache.addr`); bits [1:0] ignored.
- `flush_i` in 1: invalidate the line buffer (fence.i / pipeline flush).
- `instr_o` out 32: returned instruction word (to `icache2if.instr`).
- `ack_o` out 1: one-cycle response strobe (to `icache2if.ack`).
- `mem_req_o` out 1: refill request.
- `mem_addr_o` out ADDR_W: line-aligned refill address.
- `mem_gnt_i` in 1: refill request accepted.
- `mem_rdata_i` in 32: refill beat data.
- `mem_rvalid_i` in 1: refill beat valid; beats arrive word 0 upward, gaps allowed.

## Operation
- Line offset: `OFF_W = log2(LINE_WORDS)`. Word index is `addr_i[OFF_W+1:2]`. Tag is `addr_i[ADDR_W-1:OFF_W+2]`.
- State: `valid`, `tag`, `data[LINE_WORDS]`, beat counter (OFF_W bits), latched request word index, FSM.
- FSM states:
  - IDLE: when `req_i`=1 and no flush:
    - Hit (`valid` && tag match): register `data[idx]` into `instr_o`, pulse `ack_o` next cycle, stay in IDLE.
    - Miss: latch tag and index, go to REFILL_REQ.
  - REFILL_REQ: `mem_req_o`=1, `mem_addr_o`={tag, zeros}. Hold until `mem_gnt_i`=1, then go to REFILL_DATA and clear the beat counter.
  - REFILL_DATA: each `mem_rvalid_i` writes `data[cnt]` and increments `cnt`. On the last beat (`cnt`=LINE_WORDS-1), set `valid` and `tag` and go to RESP.
  - RESP: `ack_o`=1, `instr_o`=`data[latched idx]`, then go to IDLE.
- Requester rules:
  - Requester holds `req_i` and `addr_i` stable until `ack_o`.
  - A request presented in the same cycle as `ack_o` is a new request. It is sampled only in IDLE, so a hit gives back-to-back acks.
- Flush:
  - `flush_i` clears `valid` in any state and has priority over a same-cycle request. No ack is issued for a request sampled in that cycle.
  - Flush during REFILL_REQ or REFILL_DATA: the refill still completes its handshake and drains all beats; the memory side cannot abort. `valid` stays 0 and RESP is skipped, so no ack is issued. The FSM returns to IDLE after the last beat.
- Simultaneous `mem_rvalid_i` and `flush_i` on the last beat: data is written, `valid` is 0, no ack.

## Timing
- Reset values:
  - `instr_o`=0, `ack_o`=0, `mem_req_o`=0, `mem_addr_o`=0.
  - `valid`=0, counter=0, FSM=IDLE.
- Reset mid-refill abandons the refill immediately. Outstanding memory beats arriving after reset are ignored.
- Hit latency: `ack_o` is asserted 1 cycle after `req_i` is sampled. Throughput is one word per cycle.
- Miss timing:
  - `req_i` sampled in cycle 0.
  - `mem_req_o` asserted from cycle 1 to the grant cycle G inclusive.
  - Beats arrive after G.
  - Last beat in cycle L, `ack_o` in cycle L+1.
  - Next request sampled in cycle L+2.
- `ack_o` is never high for more than 1 consecutive cycle unless consecutive hits occur.

## Configuration
- Macro: `ICACHE_LB_EARLY_ACK_EN`.
- Defined (critical-word ack):
  - When the beat with index equal to the latched word index is written, register that beat into `instr_o` and pulse `ack_o` in the following cycle.
  - The refill continues to completion. Requests sampled before the FSM returns to IDLE get no ack; the requester holds them.
  - RESP is skipped, and the FSM goes to IDLE after the last beat.
  - Flush after the early ack still suppresses `valid`.
- Undefined: ack only in RESP, one cycle after the final beat.

## Test plan
- Reset, then `req_i` at addr 0x1000; grant after 2 cycles; beats 0xA0..0xA3 with no gaps -> `mem_addr_o`=0x1000; `ack_o` with `instr_o`=0xA0 one cycle after beat 0xA3.
- After that, request 0x100C -> `ack_o` next cycle, `instr_o`=0xA3, `mem_req_o` stays 0.
- Back-to-back 0x1004 then 0x1008 held across acks -> acks in consecutive cycles with 0xA1, 0xA2.
- Miss at 0x2006 with beats 0xB0..0xB3, one-cycle gap after beat 1 -> `mem_addr_o`=0x2000; `ack_o` with `instr_o`=0xB1 one cycle after the last beat.
- `flush_i` during REFILL_DATA of 0x3000 -> all 4 beats drained, no `ack_o`. A re-request of 0x3000 triggers a new refill.
- With `ICACHE_LB_EARLY_ACK_EN`, miss at 0x4004, beats 0xC0..0xC3 -> `ack_o` with 0xC1 one cycle after beat 1. A 0x4008 request made right after that ack gets its ack only after the FSM returns to IDLE, as a hit with 0xC2.
